// File: rtl/lm75_i2c_responder.sv
// LM75-compatible I2C slave: temperature, configuration, THYST and TOS registers,
// open-drain SDA drive and the OS over-temperature comparator.
module lm75_i2c_responder #(
    parameter logic [6:0]  I2C_ADDR    = 7'h48,
    parameter int unsigned SYNC_STAGES = 2,
    parameter logic [15:0] THYST_RST   = 16'h4B00,
    parameter logic [15:0] TOS_RST     = 16'h5000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        scl_in,
    input  logic        sda_in,
    output logic        sda_oe,
    input  logic [15:0] temp_in,
    output logic [7:0]  conf_reg,
    output logic [15:0] thyst_reg,
    output logic [15:0] tos_reg,
    output logic        os_out,
    output logic        busy
);

    localparam int unsigned NSync = (SYNC_STAGES < 2) ? 2 : SYNC_STAGES;

    typedef enum logic [2:0] {
        StIdle, StAddr, StAddrAck, StWrByte, StWrAck, StRdByte, StRdAck
    } state_t;

    state_t           state;
    logic [NSync-1:0] scl_sync, sda_sync;
    logic             scl_s, sda_s, scl_d, sda_d;
    logic             scl_rise, scl_fall, start_ev, stop_ev;
    logic [3:0]       bit_cnt;
    logic [7:0]       shift;
    logic [6:0]       tx_sh;
    logic             rw, byte_idx, wr_first, msb_pend;
    logic [1:0]       pointer;
    logic [7:0]       msb_stash;
    logic [7:0]       conf_q;
    // Only bits[15:7] of THYST/TOS/temperature carry information.
    logic [8:0]       thyst_q, tos_q, temp_snap;
    logic             os_active;
    logic [7:0]       rd_sel;
    logic             unused_temp;

    assign unused_temp = ^temp_in[6:0];

    // Pin synchronizers plus one delay stage for edge detection; idle bus level on reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            scl_sync <= '1;
            sda_sync <= '1;
            scl_d    <= 1'b1;
            sda_d    <= 1'b1;
        end else begin
            scl_sync <= {scl_sync[NSync-2:0], scl_in};
            sda_sync <= {sda_sync[NSync-2:0], sda_in};
            scl_d    <= scl_s;
            sda_d    <= sda_s;
        end
    end

    assign scl_s    = scl_sync[NSync-1];
    assign sda_s    = sda_sync[NSync-1];
    assign scl_rise = scl_s & ~scl_d;
    assign scl_fall = ~scl_s & scl_d;
    assign start_ev = scl_s & scl_d & sda_d & ~sda_s;
    assign stop_ev  = scl_s & scl_d & ~sda_d & sda_s;

    // Byte presented for the next read, selected by pointer and MSB/LSB index.
    always_comb begin
        rd_sel = 8'h00;
        case (pointer)
            2'd0:    rd_sel = byte_idx ? {temp_snap[0], 7'b0} : temp_snap[8:1];
            2'd1:    rd_sel = conf_q;
            2'd2:    rd_sel = byte_idx ? {thyst_q[0], 7'b0} : thyst_q[8:1];
            default: rd_sel = byte_idx ? {tos_q[0], 7'b0} : tos_q[8:1];
        endcase
    end

    // Bus protocol FSM and register file; START/STOP override every state.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= StIdle;
            sda_oe    <= 1'b0;
            busy      <= 1'b0;
            bit_cnt   <= 4'd0;
            shift     <= 8'h00;
            tx_sh     <= 7'h00;
            rw        <= 1'b0;
            byte_idx  <= 1'b0;
            wr_first  <= 1'b0;
            msb_pend  <= 1'b0;
            msb_stash <= 8'h00;
            pointer   <= 2'd0;
            conf_q    <= 8'h00;
            thyst_q   <= THYST_RST[15:7];
            tos_q     <= TOS_RST[15:7];
            temp_snap <= 9'd0;
        end else if (start_ev) begin
            state   <= StAddr;
            bit_cnt <= 4'd0;
            sda_oe  <= 1'b0;
        end else if (stop_ev) begin
            state  <= StIdle;
            sda_oe <= 1'b0;
            busy   <= 1'b0;
        end else begin
            unique case (state)
                StAddr: begin
                    if (scl_rise) begin
                        shift   <= {shift[6:0], sda_s};
                        bit_cnt <= bit_cnt + 4'd1;
                    end else if (scl_fall && bit_cnt == 4'd8) begin
                        if (shift[7:1] == I2C_ADDR) begin
                            state    <= StAddrAck;
                            sda_oe   <= 1'b1;
                            busy     <= 1'b1;
                            rw       <= shift[0];
                            byte_idx <= 1'b0;
                            wr_first <= 1'b1;
                            msb_pend <= 1'b0;
                            if (shift[0] && !conf_q[0]) temp_snap <= temp_in[15:7];
                        end else begin
                            state <= StIdle;
                            busy  <= 1'b0;
                        end
                    end
                end
                StAddrAck: begin
                    if (scl_fall) begin
                        bit_cnt <= 4'd0;
                        if (rw) begin
                            state  <= StRdByte;
                            tx_sh  <= rd_sel[6:0];
                            sda_oe <= ~rd_sel[7];
                        end else begin
                            state  <= StWrByte;
                            sda_oe <= 1'b0;
                        end
                    end
                end
                StWrByte: begin
                    if (scl_rise) begin
                        shift   <= {shift[6:0], sda_s};
                        bit_cnt <= bit_cnt + 4'd1;
                    end else if (scl_fall && bit_cnt == 4'd8) begin
                        state  <= StWrAck;
                        sda_oe <= 1'b1;
                        if (wr_first) begin
                            pointer  <= shift[1:0];
                            wr_first <= 1'b0;
                        end else begin
                            case (pointer)
                                2'd1: conf_q <= shift;
                                2'd2, 2'd3: begin
                                    if (!msb_pend) begin
                                        msb_stash <= shift;
                                        msb_pend  <= 1'b1;
                                    end else begin
                                        msb_pend <= 1'b0;
                                        if (pointer == 2'd2) thyst_q <= {msb_stash, shift[7]};
                                        else tos_q <= {msb_stash, shift[7]};
                                    end
                                end
                                default: ;
                            endcase
                        end
                    end
                end
                StWrAck: begin
                    if (scl_fall) begin
                        state   <= StWrByte;
                        sda_oe  <= 1'b0;
                        bit_cnt <= 4'd0;
                    end
                end
                StRdByte: begin
                    if (scl_rise) begin
                        bit_cnt <= bit_cnt + 4'd1;
                    end else if (scl_fall) begin
                        if (bit_cnt == 4'd8) begin
                            state    <= StRdAck;
                            sda_oe   <= 1'b0;
                            bit_cnt  <= 4'd0;
                            byte_idx <= ~byte_idx;
                        end else begin
                            sda_oe <= ~tx_sh[6];
                            tx_sh  <= {tx_sh[5:0], 1'b0};
                        end
                    end
                end
                StRdAck: begin
                    // bit_cnt==1 marks that the master ACKed on this ninth clock.
                    if (scl_rise) begin
                        if (sda_s) state <= StIdle;
                        else bit_cnt <= 4'd1;
                    end else if (scl_fall && bit_cnt == 4'd1) begin
                        state   <= StRdByte;
                        bit_cnt <= 4'd0;
                        tx_sh   <= rd_sel[6:0];
                        sda_oe  <= ~rd_sel[7];
                    end
                end
                default: ;
            endcase
        end
    end

    // Hysteresis comparator on signed half-degree values; frozen in shutdown.
    always_ff @(posedge clk) begin
        if (rst) begin
            os_active <= 1'b0;
        end else if (!conf_q[0]) begin
            if ($signed(temp_in[15:7]) >= $signed(tos_q)) os_active <= 1'b1;
            else if ($signed(temp_in[15:7]) < $signed(thyst_q)) os_active <= 1'b0;
        end
    end

    assign conf_reg  = conf_q;
    assign thyst_reg = {thyst_q, 7'b0};
    assign tos_reg   = {tos_q, 7'b0};
    assign os_out    = os_active ^ conf_q[2];

endmodule

// File: tb/tb_lm75_i2c_responder.sv
// Self-checking bench: bit-banged I2C master, behavioural LM75 model and a
// queue-based scoreboard compared by an independent monitor process.
module tb_lm75_i2c_responder;

    localparam int Q = 8;
    localparam logic [6:0] ADDR = 7'h48;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        scl_m = 1'b1;
    logic        sda_m = 1'b1;
    logic        scl_in, sda_in, sda_oe, os_out, busy;
    logic [15:0] temp_in = 16'h1980;
    logic [7:0]  conf_reg;
    logic [15:0] thyst_reg, tos_reg;
    logic        watch_oe = 1'b0;
    logic        oe_seen = 1'b0;

    always #20 clk = ~clk;

    assign scl_in = scl_m;
    assign sda_in = sda_m & ~sda_oe;

    lm75_i2c_responder dut (
        .clk       (clk),
        .rst       (rst),
        .scl_in    (scl_in),
        .sda_in    (sda_in),
        .sda_oe    (sda_oe),
        .temp_in   (temp_in),
        .conf_reg  (conf_reg),
        .thyst_reg (thyst_reg),
        .tos_reg   (tos_reg),
        .os_out    (os_out),
        .busy      (busy)
    );

    // Remembers whether the responder pulled SDA during a watched window.
    always @(posedge clk) oe_seen <= watch_oe ? (oe_seen | sda_oe) : 1'b0;

    // ---------------- scoreboard ----------------
    logic [15:0] exp_q[$];
    logic [15:0] obs_q[$];
    string       name_q[$];
    int          checks = 0;
    int          errors = 0;

    task automatic push_exp(input logic [15:0] e);
        exp_q.push_back(e);
    endtask

    task automatic push_obs(input string nm, input logic [15:0] a);
        name_q.push_back(nm);
        obs_q.push_back(a);
    endtask

    task automatic check(input string nm, input logic [15:0] e, input logic [15:0] a);
        push_exp(e);
        push_obs(nm, a);
    endtask

    initial begin : monitor
        logic [15:0] e, a;
        string nm;
        forever begin
            @(negedge clk);
            while (obs_q.size() > 0) begin
                a  = obs_q.pop_front();
                nm = name_q.pop_front();
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL %s: got %h, nothing expected", nm, a);
                end else begin
                    e = exp_q.pop_front();
                    if (a !== e) begin
                        errors++;
                        $display("FAIL %s: got %h, expected %h", nm, a, e);
                    end
                end
            end
        end
    end

    // ---------------- reference model ----------------
    logic [7:0]  m_conf, m_msb;
    logic [15:0] m_thyst, m_tos, m_snap;
    logic [1:0]  m_ptr;
    logic        m_os, m_pend;

    task automatic model_reset();
        m_conf = 8'h00; m_thyst = 16'h4B00; m_tos = 16'h5000; m_snap = 16'h0000;
        m_ptr = 2'd0; m_os = 1'b0; m_pend = 1'b0; m_msb = 8'h00;
    endtask

    function automatic int half(input logic [15:0] v);
        logic signed [8:0] s;
        s = v[15:7];
        return int'(s);
    endfunction

    task automatic os_step();
        if (!m_conf[0]) begin
            if (half(temp_in) >= half(m_tos)) m_os = 1'b1;
            else if (half(temp_in) < half(m_thyst)) m_os = 1'b0;
        end
    endtask

    task automatic model_write(input logic [7:0] b);
        if (m_ptr == 2'd1) begin
            m_conf = b;
        end else if (m_ptr != 2'd0) begin
            if (!m_pend) begin
                m_msb  = b;
                m_pend = 1'b1;
            end else begin
                if (m_ptr == 2'd2) m_thyst = {m_msb, b[7], 7'b0};
                else m_tos = {m_msb, b[7], 7'b0};
                m_pend = 1'b0;
            end
        end
    endtask

    function automatic logic [7:0] model_rd(input int i);
        logic [15:0] w;
        if (m_ptr == 2'd1) return m_conf;
        w = (m_ptr == 2'd0) ? m_snap : (m_ptr == 2'd2) ? m_thyst : m_tos;
        return (i % 2 == 1) ? w[7:0] : w[15:8];
    endfunction

    // ---------------- bus master ----------------
    task automatic qwait();
        repeat (Q) @(posedge clk);
    endtask

    task automatic i2c_start();
        sda_m = 1'b1; qwait(); scl_m = 1'b1; qwait(); sda_m = 1'b0; qwait();
        scl_m = 1'b0; qwait();
    endtask

    task automatic i2c_stop();
        sda_m = 1'b0; qwait(); scl_m = 1'b1; qwait(); sda_m = 1'b1; qwait();
    endtask

    task automatic clock_bit(input logic b, output logic r);
        sda_m = b; qwait(); scl_m = 1'b1; qwait();
        @(negedge clk); r = sda_in;
        qwait(); scl_m = 1'b0; qwait();
    endtask

    task automatic write_byte(input logic [7:0] b, output logic ack);
        logic r;
        for (int i = 7; i >= 0; i--) clock_bit(b[i], r);
        clock_bit(1'b1, ack);
    endtask

    task automatic read_byte(input logic nack, output logic [7:0] d);
        logic r;
        for (int i = 7; i >= 0; i--) begin
            clock_bit(1'b1, r);
            d[i] = r;
        end
        clock_bit(nack, r);
    endtask

    task automatic write_txn(input logic [7:0] ptr, input int n, input logic [7:0] d0,
                             input logic [7:0] d1, input bit do_stop);
        logic a;
        logic [7:0] d[2];
        d[0] = d0; d[1] = d1;
        i2c_start();
        push_exp(16'd0); write_byte({ADDR, 1'b0}, a); push_obs("wr_addr_ack", 16'(a));
        @(negedge clk); check("busy_in_txn", 16'd1, 16'(busy));
        m_pend = 1'b0;
        push_exp(16'd0); write_byte(ptr, a); push_obs("wr_ptr_ack", 16'(a));
        m_ptr = ptr[1:0];
        for (int i = 0; i < n; i++) begin
            push_exp(16'd0); write_byte(d[i], a); push_obs("wr_data_ack", 16'(a));
            model_write(d[i]);
        end
        if (do_stop) i2c_stop();
        @(negedge clk); os_step();
    endtask

    task automatic read_txn(input int n, input bit chg, input logic [15:0] nt);
        logic a;
        logic [7:0] d;
        i2c_start();
        if (!m_conf[0]) m_snap = {temp_in[15:7], 7'b0};
        push_exp(16'd0); write_byte({ADDR, 1'b1}, a); push_obs("rd_addr_ack", 16'(a));
        for (int i = 0; i < n; i++) begin
            push_exp(16'(model_rd(i)));
            read_byte(i == n - 1, d);
            push_obs("rd_byte", 16'(d));
            if (chg && i == 0) temp_in = nt;
        end
        @(negedge clk); check("rd_release", 16'd0, 16'(sda_oe));
        i2c_stop();
        os_step();
    endtask

    task automatic set_temp(input logic [15:0] v);
        temp_in = v;
        repeat (3) @(posedge clk);
        os_step();
        @(negedge clk);
    endtask

    task automatic check_regs(input string tag);
        @(negedge clk);
        check({tag, "_conf"}, 16'(m_conf), 16'(conf_reg));
        check({tag, "_thyst"}, m_thyst, thyst_reg);
        check({tag, "_tos"}, m_tos, tos_reg);
        check({tag, "_os"}, 16'(m_os ^ m_conf[2]), 16'(os_out));
    endtask

    initial begin : watchdog
        #4ms;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1);
    end

    // ---------------- stimulus ----------------
    initial begin : stim
        logic a, r;
        logic [15:0] sweep[4];
        logic [15:0] os_exp[4];
        model_reset();
        repeat (4) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        check("rst_sda_oe", 16'd0, 16'(sda_oe));
        check("rst_busy", 16'd0, 16'(busy));
        check_regs("rst");

        // Temperature read with pointer 0.
        read_txn(2, 1'b0, 16'h0);
        @(negedge clk); check("busy_after_stop", 16'd0, 16'(busy));

        // Comparator hysteresis, then the same sweep with inverted polarity.
        sweep[0] = 16'h4A00; sweep[1] = 16'h5000; sweep[2] = 16'h4C00; sweep[3] = 16'h4A80;
        os_exp[0] = 16'd0; os_exp[1] = 16'd1; os_exp[2] = 16'd1; os_exp[3] = 16'd0;
        for (int i = 0; i < 4; i++) begin
            set_temp(sweep[i]);
            check("os_sweep", os_exp[i], 16'(os_out));
        end
        write_txn(8'h01, 1, 8'h04, 8'h00, 1'b1);
        for (int i = 0; i < 4; i++) begin
            set_temp(sweep[i]);
            check("os_sweep_inv", 16'd1 - os_exp[i], 16'(os_out));
        end
        write_txn(8'h01, 1, 8'h00, 8'h00, 1'b1);

        // TOS write, then repeated-START read of three bytes.
        set_temp(16'h1980);
        write_txn(8'h03, 2, 8'h55, 8'h80, 1'b0);
        @(negedge clk); check("tos_written", 16'h5580, tos_reg);
        read_txn(3, 1'b0, 16'h0);

        // Address mismatch after a valid write header.
        write_txn(8'h03, 0, 8'h00, 8'h00, 1'b0);
        i2c_start();
        watch_oe = 1'b1;
        write_byte(8'h92, a);
        @(negedge clk);
        check("mis_ack", 16'd1, 16'(a));
        check("mis_oe", 16'd0, 16'(oe_seen));
        check("mis_busy", 16'd0, 16'(busy));
        watch_oe = 1'b0;
        i2c_stop();
        check_regs("mis");

        // Snapshot coherency across a temperature change mid-read.
        write_txn(8'h00, 0, 8'h00, 8'h00, 1'b0);
        read_txn(2, 1'b1, 16'h2000);

        // Repeated START mid data byte discards the partial byte.
        write_txn(8'h03, 0, 8'h00, 8'h00, 1'b0);
        for (int i = 0; i < 4; i++) clock_bit(1'b1, r);
        read_txn(2, 1'b0, 16'h0);
        check_regs("rs_mid");

        // Reset during a read data byte.
        set_temp(16'h0000);
        write_txn(8'h00, 0, 8'h00, 8'h00, 1'b0);
        i2c_start();
        m_snap = {temp_in[15:7], 7'b0};
        write_byte({ADDR, 1'b1}, a);
        for (int i = 0; i < 3; i++) clock_bit(1'b1, r);
        @(negedge clk); check("oe_before_rst", 16'd1, 16'(sda_oe));
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("oe_after_rst", 16'd0, 16'(sda_oe));
        check("busy_after_rst", 16'd0, 16'(busy));
        rst = 1'b0;
        model_reset();
        sda_m = 1'b1;
        i2c_stop();
        check_regs("post_rst");

        // Randomised traffic against the model.
        for (int it = 0; it < 16; it++) begin
            int kind, p, n;
            kind = $urandom_range(0, 3);
            if (kind == 0) begin
                if ($urandom_range(0, 1) == 1) set_temp(16'($urandom_range(16'h4400, 16'h5c00)));
                else set_temp(16'($urandom_range(0, 16'hffff)));
                check("rnd_os", 16'(m_os ^ m_conf[2]), 16'(os_out));
            end else if (kind == 1) begin
                p = $urandom_range(0, 3);
                n = (p == 1) ? 1 : (p == 0) ? $urandom_range(0, 2) : 2;
                write_txn({6'($urandom_range(0, 63)), 2'(p)}, n, 8'($urandom_range(0, 255)),
                          8'($urandom_range(0, 255)), 1'b1);
                check_regs("rnd_wr");
            end else if (kind == 2) begin
                p = $urandom_range(0, 3);
                write_txn({6'd0, 2'(p)}, 0, 8'h00, 8'h00, 1'b0);
                read_txn($urandom_range(1, 3), 1'b0, 16'h0);
            end else begin
                read_txn($urandom_range(1, 3), 1'b0, 16'h0);
            end
        end

        repeat (5) @(posedge clk);
        if (exp_q.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL scoreboard_drain: %0d expectations left, required 0", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
